// File: rtl/pe_operand_fifo.sv
// ============================================================================
// pe_operand_fifo
// ----------------------------------------------------------------------------
// Elastic operand buffer between the PE's 2:1 operand mux and the ALU stage.
// Words selected by the mux are captured under a valid/ready handshake, held
// in order (up to DEPTH entries) and the head word is presented to the ALU
// with first-word fall-through. A synchronous flush clears all entries for
// reconfiguration.
//
// Optional feature (compile-time macro PE_OPFIFO_BYPASS_EN):
//   When defined, an operand offered to an empty FIFO is forwarded to the
//   output combinationally in the same cycle. If the ALU also takes it that
//   cycle, the word is never stored. When undefined, there is no
//   combinational path from in_* to out_* and the minimum latency is 1 cycle.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   flush      in   synchronous clear of all entries (beats push and pop)
//   in_data    in   [DATA_W] operand from the mux data_out
//   in_valid   in   in_data is valid this cycle
//   in_ready   out  FIFO accepts a word this cycle (= !full)
//   out_data   out  [DATA_W] head word to the ALU (0 while nothing is valid)
//   out_valid  out  out_data is valid
//   out_ready  in   ALU consumes the head this cycle
//   count      out  [CNT_W] current occupancy, 0..DEPTH
//   full       out  count == DEPTH
//   empty      out  count == 0
// ============================================================================
module pe_operand_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic push;
    logic pop;
    logic bypass_pass;
    logic push_store;
    logic pop_store;

    // Status flags come straight from the registered count, so in_ready has
    // no path from out_ready: a full FIFO refuses a push even if it pops.
    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign in_ready = !full;

    assign push = in_valid && in_ready;

`ifdef PE_OPFIFO_BYPASS_EN
    // An empty FIFO forwards the offered word directly; if the ALU takes it
    // in the same cycle it is neither stored nor counted.
    assign out_valid   = !empty || in_valid;
    assign out_data    = !empty  ? mem_q[rd_ptr_q] :
                         in_valid ? in_data : '0;
    assign bypass_pass = empty && in_valid && out_ready;
`else
    assign out_valid   = !empty;
    // Gated to zero while empty so the idle/reset output value is defined.
    assign out_data    = empty ? '0 : mem_q[rd_ptr_q];
    assign bypass_pass = 1'b0;
`endif

    assign pop = out_valid && out_ready;

    // Only transfers that touch storage move pointers and count. A pop on an
    // empty FIFO (only possible via bypass) never reads storage.
    assign push_store = push && !bypass_pass;
    assign pop_store  = pop  && !empty;

    // Next-state logic: flush wins over any push/pop in the same cycle.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so natural pointer overflow is the wrap.
            if (push_store) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_store)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            unique case ({push_store, pop_store})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is data only; its contents after reset are irrelevant because
    // the output is gated by the registered count.
    always_ff @(posedge clk) begin
        if (push_store && !flush) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

endmodule

// File: tb/tb_pe_operand_fifo.sv
// ============================================================================
// tb_pe_operand_fifo
// ----------------------------------------------------------------------------
// Directed, self-checking bench for pe_operand_fifo (DATA_W=32, DEPTH=4).
// Inputs change 1 time unit after a rising edge; outputs are sampled there,
// away from the active edge. Expected values are hand-derived constants.
// ============================================================================
`timescale 1ns/1ps
module tb_pe_operand_fifo;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic              clk;
    logic              rst_n;
    logic              flush;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;

    int errors = 0;
    int checks = 0;

    pe_operand_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog: the run is a fixed number of cycles, this only guards a hang.
    initial begin
        #20000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] v);
        in_valid = 1'b1;
        in_data  = v;
        tick();
        in_valid = 1'b0;
    endtask

    logic [31:0] seq [4];
    logic [31:0] bp  [4];

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        seq[0] = 32'hA5A5A5A5; seq[1] = 32'h5A5A5A5A;
        seq[2] = 32'hFFFFFFFF; seq[3] = 32'h00000000;
        bp[0]  = 32'h22222222; bp[1]  = 32'h33333333;
        bp[2]  = 32'h44444444; bp[3]  = 32'h87654321;

        // ---------------- reset state ----------------
        #12;
        check("rst_count",     32'(count),     0);
        check("rst_empty",     32'(empty),     1);
        check("rst_full",      32'(full),      0);
        check("rst_in_ready",  32'(in_ready),  1);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data",  out_data,       0);
        rst_n = 1'b1;
        tick();

        // ---------------- ordering and wrap ----------------
        for (int i = 0; i < 4; i++) push_word(seq[i]);
        check("ord_full",     32'(full),     1);
        check("ord_in_ready", 32'(in_ready), 0);
        check("ord_count",    32'(count),    4);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("ord_pop%0d_valid", i), 32'(out_valid), 1);
            check($sformatf("ord_pop%0d_data", i),  out_data,       seq[i]);
            tick();
        end
        out_ready = 1'b0;
        check("ord_empty_after", 32'(empty), 1);
        push_word(32'h12345678);
        check("wrap_data",  out_data,   32'h12345678);
        check("wrap_count", 32'(count), 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("wrap_drained", 32'(empty), 1);

        // ---------------- full backpressure ----------------
        push_word(32'h11111111);
        for (int i = 0; i < 3; i++) push_word(bp[i]);
        check("bp_full", 32'(full), 1);
        in_valid  = 1'b1;
        in_data   = 32'h87654321;
        out_ready = 1'b1;
        check("bp_in_ready_low", 32'(in_ready), 0);
        check("bp_head",         out_data,      32'h11111111);
        tick();
        check("bp_count_after_pop", 32'(count), 3);
        out_ready = 1'b0;
        check("bp_in_ready_high", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        check("bp_count_after_push", 32'(count), 4);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("bp_pop%0d", i), out_data, bp[i]);
            tick();
        end
        out_ready = 1'b0;
        check("bp_empty", 32'(empty), 1);

        // ---------------- simultaneous push/pop streaming ----------------
        push_word(32'h00000100);
        push_word(32'h00000101);
        check("str_count_start", 32'(count), 2);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data = 32'h00000102 + 32'(i);
            check($sformatf("str_head%0d", i), out_data, 32'h00000100 + 32'(i));
            tick();
            check($sformatf("str_count%0d", i), 32'(count), 2);
        end
        in_valid = 1'b0;
        check("str_tail0", out_data, 32'h0000010A);
        tick();
        check("str_tail1", out_data, 32'h0000010B);
        tick();
        out_ready = 1'b0;
        check("str_empty", 32'(empty), 1);

        // ---------------- flush ----------------
        push_word(32'h000000C0);
        push_word(32'h000000C1);
        push_word(32'h000000C2);
        check("fl_count_pre", 32'(count), 3);
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'hBAD0BAD0;
        out_ready = 1'b1;
        tick();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("fl_count",     32'(count),     0);
        check("fl_empty",     32'(empty),     1);
        check("fl_out_valid", 32'(out_valid), 0);
        check("fl_in_ready",  32'(in_ready),  1);
        push_word(32'h00000055);
        check("fl_next_word", out_data,   32'h00000055);
        check("fl_next_cnt",  32'(count), 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // ---------------- asynchronous reset mid-run ----------------
        push_word(32'h0000AAA1);
        push_word(32'h0000AAA2);
        push_word(32'h0000AAA3);
        check("ar_count_pre", 32'(count), 3);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_count",     32'(count),     0);
        check("ar_empty",     32'(empty),     1);
        check("ar_in_ready",  32'(in_ready),  1);
        check("ar_out_valid", 32'(out_valid), 0);
        check("ar_out_data",  out_data,       0);
        #2;
        rst_n = 1'b1;
        tick();
        check("ar_still_empty", 32'(empty), 1);

        // ---------------- bypass / minimum latency ----------------
        in_valid  = 1'b1;
        in_data   = 32'hDEADBEEF;
        out_ready = 1'b1;
        #1;
`ifdef PE_OPFIFO_BYPASS_EN
        check("byp_same_valid", 32'(out_valid), 1);
        check("byp_same_data",  out_data,       32'hDEADBEEF);
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("byp_count", 32'(count), 0);
        check("byp_empty", 32'(empty), 1);
`else
        check("lat_same_valid", 32'(out_valid), 0);
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("lat_next_valid", 32'(out_valid), 1);
        check("lat_next_data",  out_data,       32'hDEADBEEF);
        check("lat_count",      32'(count),     1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pe_operand_fifo.md
Name: pe_operand_fifo

Overview:
- Elastic operand buffer directly downstream of the PE's 32-bit 2:1 operand mux.
- Captures the selected operand (mux data_out) under a valid/ready handshake and holds up to DEPTH words in order.
- Presents the head word to the PE ALU stage, decoupling operand selection from ALU stalls.
- Includes occupancy reporting and a synchronous flush for reconfiguration.

Parameters:
- DATA_W, 32, operand width; matches the mux data path.
- DEPTH, 4, number of entries; power of 2, at least 2.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear of all entries.
- in_data  input  DATA_W  operand from the mux data_out.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  FIFO accepts a word this cycle.
- out_data  output  DATA_W  head word to the ALU.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  ALU consumes the head this cycle.
- count  output  CNT_W  current occupancy, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, in_ready=1, out_valid=0, out_data=0. Storage contents are don't-care.
- Push: occurs when in_valid && in_ready. Writes mem[wr_ptr]; wr_ptr increments modulo DEPTH.
- Pop: occurs when out_valid && out_ready. rd_ptr increments modulo DEPTH.
- in_ready = !full. It is registered-state-derived and has no combinational path from out_ready. A push into a full FIFO is never accepted, even if a pop happens in the same cycle.
- out_valid = !empty. out_data = mem[rd_ptr], read combinationally from the head (first-word fall-through).
- Latency: a word pushed at edge N appears on out_data/out_valid after edge N, so the ALU can pop it in cycle N+1.
- Count update per cycle:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged; the head advances and the new word is appended.
- Ordering: strict FIFO. The pointer wrap from DEPTH-1 to 0 is seamless.
- Empty FIFO: out_ready is ignored; no pointer or count change.
- Full FIFO: in_valid is held off by in_ready=0. The upstream mux must hold in_data stable until it is accepted.
- Flush:
  - Takes priority over push and pop in the same cycle.
  - Next state: pointers=0, count=0, out_valid=0, in_ready=1.
  - The word offered that cycle is discarded.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). No partial word survives.
- full, empty and count are all derived from the registered count; no glitch paths.

Optional Feature:
- Macro: PE_OPFIFO_BYPASS_EN.
- When defined, empty-FIFO bypass is enabled. If empty && in_valid:
  - out_valid=1 and out_data=in_data combinationally in the same cycle.
  - If out_ready is also 1, the word passes through without being stored; count stays 0 and pointers are unchanged.
  - Otherwise the word is stored normally.
- When not defined: minimum latency is 1 cycle, and there is no combinational path from in_* to out_*.

Test Plan:
- Reset: assert rst_n=0 mid-run with count=3 -> count=0, empty=1, in_ready=1, out_valid=0 asynchronously; out_data=0.
- Ordering and wrap: push 32'hA5A5A5A5, 32'h5A5A5A5A, 32'hFFFFFFFF, 32'h00000000 with out_ready=0 -> full=1, in_ready=0, count=4. Then pop all -> the same sequence in order. Then push 32'h12345678 -> it appears at rd_ptr=0 after the wrap.
- Full backpressure: with the FIFO full, hold in_valid=1 with 32'h87654321 and out_ready=1 for one cycle -> no push that cycle, count=3. Next cycle the push is accepted and count=4. 32'h87654321 emerges last.
- Simultaneous push/pop at count=2 -> count stays 2 and the head advances. The output order is preserved across 10 cycles of continuous streaming.
- Flush: flush=1 with in_valid=1 and out_ready=1 at count=3 -> next cycle count=0, empty=1. The offered word is never output.
- Bypass (PE_OPFIFO_BYPASS_EN): when empty, drive in_valid=1, in_data=32'hDEADBEEF, out_ready=1 -> out_valid=1 and out_data=32'hDEADBEEF in the same cycle, count remains 0. Without the macro, out_valid rises one cycle later.
